// File: rtl/cam_timing_gen.sv
// Emulated parallel camera source: divided pixel clock, line/frame counters, href/vsync
// and a selectable test pattern, all updated on pclk falling edges.
module cam_timing_gen #(
    parameter int                DATA_W      = 8,
    parameter int                PCLK_DIV    = 32,
    parameter int                H_ACTIVE    = 1280,
    parameter int                H_BLANK     = 288,
    parameter int                VSYNC_LINES = 3,
    parameter int                VBP_LINES   = 17,
    parameter int                V_ACTIVE    = 480,
    parameter int                VFP_LINES   = 10,
    parameter bit                VSYNC_POL   = 1'b1,
    parameter logic [DATA_W-1:0] SEED        = DATA_W'(8'h60),
    parameter int                STEP        = 3,
    parameter int                CHK_LOG2    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fixed_value,
    output logic              pclk,
    output logic              href,
    output logic              vsync,
    output logic [DATA_W-1:0] cam_data,
    output logic              frame_start,
    output logic [15:0]       frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DVW     = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int SEG     = H_ACTIVE / 8;
    localparam int SW      = (SEG > 1) ? $clog2(SEG) : 1;

    localparam logic [DVW-1:0]    DIV_LAST    = DVW'(PCLK_DIV - 1);
    localparam logic [HW-1:0]     H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT       = HW'(H_ACTIVE);
    localparam logic [VW-1:0]     V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_SYNC      = VW'(VSYNC_LINES);
    localparam logic [VW-1:0]     V_ACT_FIRST = VW'(VSYNC_LINES + VBP_LINES);
    localparam logic [VW-1:0]     V_ACT_END   = VW'(VSYNC_LINES + VBP_LINES + V_ACTIVE);
    localparam logic [SW-1:0]     SEG_LAST    = SW'(SEG - 1);
    localparam logic [DATA_W-1:0] STEP_V      = DATA_W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DVW-1:0]    div_q;
    logic              pclk_q;
    logic              tick;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [SW-1:0]     sub_q, sub_d;
    logic [2:0]        bar_q, bar_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fixed_q, fixed_d;
    logic [DATA_W-1:0] ramp_q, ramp_d, ramp_base;
    logic [DATA_W-1:0] data_q, data_d;
    logic              href_q, href_d;
    logic              vsync_q, vsync_d;
    logic              fs_q, fs_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              start, frame_end, active, chk_bit;
    logic [VW-1:0]     line_idx;

    // A pixel tick is the clk cycle on which pclk is driven from 1 to 0.
    assign tick = pclk_q && (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            pclk_q  <= 1'b0;
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            sub_q   <= '0;
            bar_q   <= '0;
            mode_q  <= '0;
            fixed_q <= '0;
            ramp_q  <= '0;
            data_q  <= '0;
            href_q  <= 1'b0;
            vsync_q <= ~VSYNC_POL;
            fs_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            div_q   <= (div_q == DIV_LAST) ? '0 : div_q + DVW'(1);
            if (div_q == DIV_LAST) begin
                pclk_q <= ~pclk_q;
            end
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            sub_q   <= sub_d;
            bar_q   <= bar_d;
            mode_q  <= mode_d;
            fixed_q <= fixed_d;
            ramp_q  <= ramp_d;
            data_q  <= data_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state and raster position. DRAIN only differs from RUN in that a frame
    // ending there returns to IDLE instead of starting the next one.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        sub_d     = sub_q;
        bar_d     = bar_q;
        start     = 1'b0;
        frame_end = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_RUN;
                        start   = 1'b1;
                    end
                end
                default: begin
                    frame_end = (h_q == H_LAST) && (v_q == V_LAST);
                    if (h_q == H_LAST) begin
                        h_d   = '0;
                        sub_d = '0;
                        bar_d = '0;
                        v_d   = (v_q == V_LAST) ? '0 : v_q + VW'(1);
                    end else begin
                        h_d = h_q + HW'(1);
                        if (sub_q == SEG_LAST) begin
                            sub_d = '0;
                            bar_d = bar_q + 3'd1;
                        end else begin
                            sub_d = sub_q + SW'(1);
                        end
                    end
                    if (frame_end) begin
                        if (enable) begin
                            state_d = S_RUN;
                            start   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = enable ? S_RUN : S_DRAIN;
                    end
                end
            endcase
        end
        mode_d  = start ? mode : mode_q;
        fixed_d = start ? fixed_value : fixed_q;
    end

    // Outputs describe the position being entered on this tick.
    always_comb begin
        href_d    = href_q;
        vsync_d   = vsync_q;
        data_d    = data_q;
        ramp_d    = ramp_q;
        fs_d      = 1'b0;
        fcnt_d    = fcnt_q;
        ramp_base = start ? SEED : ramp_q;
        line_idx  = v_d - V_ACT_FIRST;
        active    = (state_d != S_IDLE) && (v_d >= V_ACT_FIRST) && (v_d < V_ACT_END)
                    && (h_d < H_ACT);
        chk_bit   = |((32'(h_d) ^ 32'(line_idx)) & (32'd1 << CHK_LOG2));
        if (tick) begin
            href_d  = active;
            vsync_d = ((state_d != S_IDLE) && (v_d < V_SYNC)) ? VSYNC_POL : ~VSYNC_POL;
            ramp_d  = ramp_base;
            data_d  = '0;
            if (start) begin
                fs_d   = 1'b1;
                fcnt_d = fcnt_q + 16'd1;
            end
            if (active) begin
                unique case (mode_d)
                    2'd0: begin
                        data_d = ramp_base;
                        ramp_d = ramp_base + STEP_V;
                    end
                    2'd1:    data_d = fixed_d;
                    2'd2:    data_d = {bar_d, {(DATA_W-3){1'b0}}};
                    default: data_d = chk_bit ? '1 : '0;
                endcase
            end
        end
    end

    assign pclk        = pclk_q;
    assign href        = href_q;
    assign vsync       = vsync_q;
    assign cam_data    = data_q;
    assign frame_start = fs_q;
    assign frame_count = fcnt_q;

endmodule
